// File: rtl/letc_core_pkg.sv
// Shared types for the LETC core pipeline.
// Holds the per-stage controller state encoding and small helpers.
// Imported by the stage controller and its sub-modules.
package letc_core_pkg;

  typedef enum logic [1:0] {
    SC_IDLE    = 2'd0,
    SC_REQ     = 2'd1,
    SC_DONE    = 2'd2,
    SC_ABANDON = 2'd3
  } stage_ctrl_state_e;

  // True in the states where a side operation is outstanding on op_req.
  function automatic logic sc_op_busy(input stage_ctrl_state_e s);
    return (s == SC_REQ) || (s == SC_ABANDON);
  endfunction

endpackage

// File: rtl/letc_core_sat_counter.sv
// Saturating up-counter with synchronous clear, used as the op watchdog.
// Latency: count updates one cycle after inc/clr; at_max is combinational from count.
// Backpressure: none; clr wins over inc, count sticks at MAX until cleared.
module letc_core_sat_counter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned MAX   = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             at_max
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: clear has priority, increment stops at MAX.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != MAX_V)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign at_max = (count_q == MAX_V);

endmodule

// File: rtl/letc_core_stage_ctrl.sv
// Per-stage stall/flush endpoint: output pipeline register plus one req/ack side op.
// Latency: payload registered 1 cycle; op requested the cycle after arrival, ready the cycle after op_ack.
// Backpressure: stage_ready held low while the op is outstanding; stage_stall holds all outputs.
module letc_core_stage_ctrl
  import letc_core_pkg::*;
#(
  parameter int unsigned PAYLOAD_W      = 32,
  parameter int unsigned RDATA_W        = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic                 in_needs_op,
  input  logic                 stage_stall,
  input  logic                 stage_flush,
  output logic                 stage_ready,
  output logic                 op_req,
  input  logic                 op_ack,
  input  logic [RDATA_W-1:0]   op_rdata,
  output logic                 out_valid,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [RDATA_W-1:0]   out_rdata,
  output logic                 op_timeout
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  stage_ctrl_state_e    state_q, state_d;
  logic [RDATA_W-1:0]   result_q, result_d;
  logic                 out_valid_q, out_valid_d;
  logic [PAYLOAD_W-1:0] out_payload_q, out_payload_d;
  logic [RDATA_W-1:0]   out_rdata_q, out_rdata_d;
  logic                 op_timeout_q, op_timeout_d;

  logic                 want_op;
  logic                 busy;
  logic [WD_W-1:0]      wd_count;
  logic                 wd_at_max;

  assign want_op = in_valid && in_needs_op;
  assign busy    = sc_op_busy(state_q);

  // Op sequencer: next state, result capture, op_req and stage_ready.
  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    op_req      = 1'b0;
    stage_ready = 1'b1;
    unique case (state_q)
      SC_IDLE: begin
        if (want_op) begin
          stage_ready = 1'b0;
          if (!stage_flush) state_d = SC_REQ;
        end
      end
      SC_REQ: begin
        op_req      = 1'b1;
        stage_ready = 1'b0;
        if (op_ack) begin
          // A flush landing on the ack cycle throws the result away.
          if (!stage_flush) begin
            result_d = op_rdata;
            state_d  = SC_DONE;
          end else begin
            state_d = SC_IDLE;
          end
        end else if (stage_flush) begin
          // The responder still owes us an ack; keep op_req up until it arrives.
          state_d = SC_ABANDON;
        end
      end
      SC_DONE: begin
        if (stage_flush || !stage_stall) state_d = SC_IDLE;
      end
      SC_ABANDON: begin
        op_req      = 1'b1;
        stage_ready = 1'b0;
        if (op_ack) state_d = SC_IDLE;
      end
      default: state_d = SC_IDLE;
    endcase
  end

  // Output pipeline register: flush kills, stall holds, otherwise load.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_payload_d = out_payload_q;
    out_rdata_d   = out_rdata_q;
    if (stage_flush) begin
      out_valid_d = 1'b0;
    end else if (!stage_stall) begin
      // A non-ready instruction never advances, even if the stall is missing.
      out_valid_d   = in_valid && stage_ready;
      out_payload_d = in_payload;
      out_rdata_d   = in_needs_op ? result_q : '0;
    end
  end

  // Watchdog counts cycles with an op outstanding.
  letc_core_sat_counter #(
    .WIDTH (WD_W),
    .MAX   (TIMEOUT_CYCLES)
  ) u_wd (
    .clk    (clk),
    .rst    (rst),
    .inc    (busy),
    .clr    (!busy),
    .count  (wd_count),
    .at_max (wd_at_max)
  );

  assign op_timeout_d = op_timeout_q || wd_at_max;

  // State, result and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= SC_IDLE;
      result_q      <= '0;
      out_valid_q   <= 1'b0;
      out_payload_q <= '0;
      out_rdata_q   <= '0;
      op_timeout_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      result_q      <= result_d;
      out_valid_q   <= out_valid_d;
      out_payload_q <= out_payload_d;
      out_rdata_q   <= out_rdata_d;
      op_timeout_q  <= op_timeout_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_payload = out_payload_q;
  assign out_rdata   = out_rdata_q;
  // Visible in the same cycle the counter saturates; the flop keeps it afterwards.
  assign op_timeout  = op_timeout_q || wd_at_max;

`ifndef SYNTHESIS
  a_no_x_ctrl: assert property (@(posedge clk) disable iff (rst)
    !$isunknown({stage_ready, op_req, out_valid, op_timeout}));
  a_req_hold: assert property (@(posedge clk) disable iff (rst)
    (op_req && !op_ack) |=> op_req);
  a_ack_in_req: assert property (@(posedge clk) disable iff (rst)
    op_ack |-> op_req);
  a_stall_when_busy: assert property (@(posedge clk) disable iff (rst)
    (!stage_ready && !stage_flush) |-> stage_stall);
  a_out_hold: assert property (@(posedge clk) disable iff (rst)
    (stage_stall && !stage_flush) |=> ($stable(out_valid) && $stable(out_payload)));
  a_wd_sat: assert property (@(posedge clk) disable iff (rst)
    wd_count <= WD_W'(TIMEOUT_CYCLES));
`endif

endmodule
